// File: rtl/chan_scan_mux_pkg.sv
// Shared encodings for the channel scan multiplexer: FSM states and operating modes.
package chan_scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DWELL   = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  localparam logic [1:0] MODE_MAN   = 2'b00;
  localparam logic [1:0] MODE_SCAN1 = 2'b01;
  localparam logic [1:0] MODE_SCANC = 2'b10;

endpackage

// File: rtl/chan_scan_mux_next_en_chan.sv
// Finds the next enabled channel in a mask: lowest set bit, or the first set bit strictly
// above cur with wrap-around to the lowest when nothing lies above.
module chan_scan_mux_next_en_chan #(
  parameter  int unsigned NCH  = 8,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur,
  input  logic            from_bottom,
  output logic [SELW-1:0] nxt,
  output logic            found,
  output logic            wrapped
);

  logic [SELW-1:0] w_low;
  logic [SELW-1:0] w_above;
  logic            w_has_above;

  // Descending walk so the last hit is the lowest qualifying index.
  always_comb begin
    w_low       = '0;
    w_above     = '0;
    w_has_above = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        w_low = SELW'(k);
        if (SELW'(k) > cur) begin
          w_above     = SELW'(k);
          w_has_above = 1'b1;
        end
      end
    end
  end

  assign found   = |mask;
  assign wrapped = ~from_bottom & ~w_has_above;
  assign nxt     = (from_bottom | ~w_has_above) ? w_low : w_above;

endmodule

// File: rtl/chan_scan_mux.sv
// Registered NCH x W-bit multiplexer with manual select, one-pass and continuous channel
// scanning, per-channel enable mask, settle dwell and a valid/ready output handshake.
module chan_scan_mux
  import chan_scan_mux_pkg::*;
#(
  parameter  int unsigned NCH   = 8,
  parameter  int unsigned W     = 8,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SELW  = $clog2(NCH),
  localparam int unsigned DCW   = $clog2(DWELL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   chan_en,
  input  logic [1:0]       mode,
  input  logic [SELW-1:0]  sel,
  input  logic             start,
  input  logic             stop,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             empty_err
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  state_e          r_state;
  logic [1:0]      r_mode;
  logic [SELW-1:0] r_ptr;
  logic [DCW-1:0]  r_cnt;
  logic            r_stop;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_chan;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_empty_err;

  state_e          w_state_nxt;
  logic [1:0]      w_mode_nxt;
  logic [SELW-1:0] w_ptr_nxt;
  logic [DCW-1:0]  w_cnt_nxt;
  logic            w_stop_nxt;
  logic [W-1:0]    w_data_nxt;
  logic [SELW-1:0] w_chan_nxt;
  logic            w_valid_nxt;
  logic            w_err_nxt;

  logic [1:0]      w_start_mode;
  logic [SELW-1:0] w_sel_clamp;
  logic [SELW-1:0] w_cap_idx;
  logic [W-1:0]    w_lane;
  logic            w_xfer;
  logic            w_stop_any;
  logic [SELW-1:0] w_nxt;
  logic            w_found;
  logic            w_wrapped;

  // One lookup serves both the first-channel search (IDLE) and the advance (PRESENT).
  chan_scan_mux_next_en_chan #(
    .NCH (NCH)
  ) u_next_en_chan (
    .mask        (chan_en),
    .cur         (r_ptr),
    .from_bottom (r_state == ST_IDLE),
    .nxt         (w_nxt),
    .found       (w_found),
    .wrapped     (w_wrapped)
  );

  assign w_start_mode = (mode == 2'b11) ? MODE_MAN : mode;
  assign w_sel_clamp  = (sel > LAST_CH) ? LAST_CH : sel;
  assign w_cap_idx    = (r_state == ST_IDLE) ? w_sel_clamp : r_ptr;
  assign w_lane       = in_data[int'(w_cap_idx) * W +: W];
  assign w_xfer       = r_out_valid & out_ready;
  assign w_stop_any   = r_stop | stop;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_stop_nxt  = r_stop;
    w_data_nxt  = r_out_data;
    w_chan_nxt  = r_out_chan;
    w_valid_nxt = r_out_valid;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_stop_nxt = 1'b0;
        if (start) begin
          if (w_start_mode == MODE_MAN) begin
            w_mode_nxt  = MODE_MAN;
            w_data_nxt  = w_lane;
            w_chan_nxt  = w_sel_clamp;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_PRESENT;
          end else if (w_found) begin
            w_mode_nxt  = w_start_mode;
            w_ptr_nxt   = w_nxt;
            w_cnt_nxt   = DCW'(DWELL);
            w_state_nxt = ST_DWELL;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_DWELL: begin
        w_stop_nxt = w_stop_any;
        if (w_stop_any) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == DCW'(1)) begin
          w_data_nxt  = w_lane;
          w_chan_nxt  = r_ptr;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else begin
          w_cnt_nxt = r_cnt - DCW'(1);
        end
      end
      ST_PRESENT: begin
        w_stop_nxt = w_stop_any;
        if (w_xfer) begin
          w_valid_nxt = 1'b0;
          if ((r_mode == MODE_MAN) || w_stop_any) begin
            w_state_nxt = ST_IDLE;
          end else if (!w_found) begin
            // Mask emptied under a running scan.
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end else if (w_wrapped && (r_mode == MODE_SCAN1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_ptr_nxt   = w_nxt;
            w_cnt_nxt   = DCW'(DWELL);
            w_state_nxt = ST_DWELL;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_MAN;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_stop      <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_empty_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stop      <= w_stop_nxt;
      r_out_data  <= w_data_nxt;
      r_out_chan  <= w_chan_nxt;
      r_out_valid <= w_valid_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_empty_err <= w_err_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign empty_err = r_empty_err;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: manual-select vector table, directed scan/stop/reset sequences and
// randomized one-pass scans checked against an ordered list of enabled channels.
module tb_chan_scan_mux;

  localparam int unsigned DWELL = 4;
  localparam logic [63:0] P8 = 64'h7869_A54B_3C2D_1E0F;
  localparam logic [47:0] P6 = 48'hC5C4_C3C2_C1C0;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [7:0]  chan_en;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic        start;
  logic        stop;
  logic [7:0]  out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        empty_err;

  logic [47:0] in_data6;
  logic [5:0]  chan_en6;
  logic [1:0]  mode6;
  logic [2:0]  sel6;
  logic        start6;
  logic        stop6;
  logic [7:0]  out_data6;
  logic [2:0]  out_chan6;
  logic        out_valid6;
  logic        out_ready6;
  logic        busy6;
  logic        empty_err6;

  int n_pass;
  int n_total;

  chan_scan_mux #(.NCH(8), .W(8), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .chan_en(chan_en), .mode(mode), .sel(sel),
    .start(start), .stop(stop), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .empty_err(empty_err)
  );

  chan_scan_mux #(.NCH(6), .W(8), .DWELL(DWELL)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .chan_en(chan_en6), .mode(mode6), .sel(sel6),
    .start(start6), .stop(stop6), .out_data(out_data6), .out_chan(out_chan6),
    .out_valid(out_valid6), .out_ready(out_ready6), .busy(busy6), .empty_err(empty_err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       six;
    logic [1:0] mode;
    logic [2:0] sel;
    logic [2:0] exp_chan;
    logic [7:0] exp_data;
  } man_vec_t;

  man_vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] lane8(input logic [63:0] d, input int ch);
    return d[ch*8 +: 8];
  endfunction

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_total++;
      $display("FAIL %s: out_valid not seen within 64 cycles", name);
    end
  endtask

  // One-pass scan with random backpressure; expected order is the ascending enabled list.
  task automatic run_scan1(input string name, input logic [7:0] mask, input int ready_pct);
    int exp_q[$];
    int ref_cnt;
    int exp_ch;
    logic prev_valid;
    logic rdy;
    logic done;
    logic last;
    for (int k = 0; k < 8; k++) if (mask[k]) exp_q.push_back(k);
    mode = 2'b01;
    chan_en = mask;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ref_cnt = 0;
    prev_valid = 1'b0;
    done = 1'b0;
    exp_ch = exp_q[0];
    for (int c = 0; c < 400 && !done; c++) begin
      last = 1'b0;
      if (out_valid && !prev_valid) chk({name, "_latency"}, 64'(ref_cnt), 64'(DWELL));
      if (out_valid && prev_valid) begin
        chk({name, "_hold_chan"}, 64'(out_chan), 64'(exp_ch));
        chk({name, "_hold_data"}, 64'(out_data), 64'(lane8(in_data, exp_ch)));
      end
      prev_valid = out_valid;
      rdy = ($urandom_range(99) < 32'(ready_pct));
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL %s_extra: unexpected sample chan %0d", name, out_chan);
          done = 1'b1;
        end else begin
          exp_ch = exp_q.pop_front();
          chk({name, "_chan"}, 64'(out_chan), 64'(exp_ch));
          chk({name, "_data"}, 64'(out_data), 64'(lane8(in_data, exp_ch)));
          if (exp_q.size() == 0) last = 1'b1;
          else exp_ch = exp_q[0];
        end
        ref_cnt = -1;
        prev_valid = 1'b0;
      end
      @(negedge clk);
      ref_cnt++;
      if (last) begin
        chk({name, "_end_busy"}, 64'(busy), 64'd0);
        chk({name, "_end_valid"}, 64'(out_valid), 64'd0);
        done = 1'b1;
      end
    end
    out_ready = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL %s_timeout: %0d samples never delivered", name, exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{1'b0, 2'b00, 3'd5, 3'd5, 8'hA5};
    vecs[1] = '{1'b0, 2'b11, 3'd0, 3'd0, 8'h0F};
    vecs[2] = '{1'b0, 2'b00, 3'd7, 3'd7, 8'h78};
    vecs[3] = '{1'b0, 2'b11, 3'd3, 3'd3, 8'h3C};
    vecs[4] = '{1'b1, 2'b00, 3'd7, 3'd5, 8'hC5};
    vecs[5] = '{1'b1, 2'b00, 3'd6, 3'd5, 8'hC5};
    vecs[6] = '{1'b1, 2'b11, 3'd2, 3'd2, 8'hC2};
    vecs[7] = '{1'b1, 2'b00, 3'd0, 3'd0, 8'hC0};

    rst = 1'b1;
    in_data = P8;  chan_en = '0;  mode = '0;  sel = '0;  start = 1'b0;  stop = 1'b0;
    out_ready = 1'b0;
    in_data6 = P6; chan_en6 = '0; mode6 = '0; sel6 = '0; start6 = 1'b0; stop6 = 1'b0;
    out_ready6 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_chan", 64'(out_chan), 64'd0);
    chk("rst_err", 64'(empty_err), 64'd0);

    // Manual selection table, including out-of-range select on the 6-channel instance.
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b1;
      if (vecs[i].six) begin
        mode6 = vecs[i].mode; sel6 = vecs[i].sel; start6 = 1'b1;
      end else begin
        mode = vecs[i].mode; sel = vecs[i].sel; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      start6 = 1'b0;
      if (vecs[i].six) begin
        chk($sformatf("man%0d_valid", i), 64'(out_valid6), 64'd1);
        chk($sformatf("man%0d_chan", i), 64'(out_chan6), 64'(vecs[i].exp_chan));
        chk($sformatf("man%0d_data", i), 64'(out_data6), 64'(vecs[i].exp_data));
      end else begin
        chk($sformatf("man%0d_valid", i), 64'(out_valid), 64'd1);
        chk($sformatf("man%0d_chan", i), 64'(out_chan), 64'(vecs[i].exp_chan));
        chk($sformatf("man%0d_data", i), 64'(out_data), 64'(vecs[i].exp_data));
      end
      @(negedge clk);
      if (vecs[i].six) chk($sformatf("man%0d_idle", i), 64'({busy6, out_valid6, empty_err6}), 64'd0);
      else chk($sformatf("man%0d_idle", i), 64'({busy, out_valid}), 64'd0);
    end

    // Reset while presenting a scanned sample.
    out_ready = 1'b0; mode = 2'b01; chan_en = 8'h08; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("rstmid_wait");
    chk("rstmid_chan", 64'(out_chan), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_data", 64'(out_data), 64'd0);

    // One pass over ch0, ch2, ch7 with the consumer always ready.
    in_data = P8;
    run_scan1("pass85", 8'h85, 100);

    // Backpressure: sample held for 10 cycles, then one transfer advances the scan.
    out_ready = 1'b0; mode = 2'b01; chan_en = 8'h06; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("bp_wait");
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_chan", 64'(out_chan), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'h1E);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_fall", 64'(out_valid), 64'd0);
    wait_valid("bp_wait2");
    chk("bp_next_chan", 64'(out_chan), 64'd2);
    chk("bp_next_data", 64'(out_data), 64'h2D);
    @(negedge clk);
    chk("bp_end_busy", 64'(busy), 64'd0);

    // Continuous scan ch0/ch1, stopped during the dwell of ch1.
    out_ready = 1'b1; mode = 2'b10; chan_en = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_valid("cont_wait");
      chk($sformatf("cont%0d_chan", i), 64'(out_chan), 64'(i % 2));
      chk($sformatf("cont%0d_data", i), 64'(out_data), 64'(lane8(P8, i % 2)));
      @(negedge clk);
    end
    chk("cont_in_dwell", 64'({busy, out_valid}), 64'b10);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_valid", 64'(out_valid), 64'd0);
    repeat (6) @(negedge clk);
    chk("stop_no_sample", 64'(out_valid), 64'd0);

    // Scan start with an empty mask.
    mode = 2'b01; chan_en = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_err_pulse", 64'(empty_err), 64'd1);
    chk("empty_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("empty_err_clear", 64'(empty_err), 64'd0);

    // Mask cleared while a continuous scan presents its sample.
    out_ready = 1'b0; mode = 2'b10; chan_en = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("mzero_wait");
    chk("mzero_chan", 64'(out_chan), 64'd4);
    chan_en = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mzero_err", 64'(empty_err), 64'd1);
    chk("mzero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("mzero_err_clear", 64'(empty_err), 64'd0);

    // Randomized one-pass scans.
    for (int r = 0; r < 12; r++) begin
      in_data = {$urandom, $urandom};
      run_scan1($sformatf("rnd%0d", r), 8'($urandom_range(1, 255)), int'($urandom_range(30, 100)));
      repeat (2) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
